// File: rtl/gpu_reg_bridge.sv
// ---------------------------------------------------------------------------
// gpu_reg_bridge
//
// This module is the Avalon-MM slave front end between the HPS lightweight
// bridge and the GPU's bank of dual-load control registers.
//
// Host writes are handled in three steps:
//   - The request is latched.
//   - It is byte-merged with the target register's current Q value.
//   - The merged value is presented on the shared reg_d bus, together with a
//     one-cycle, active-low, one-hot primary load strobe.
//
// Host reads return the selected register's Q value. One word past the
// register bank is a read-only STATUS word: {30'b0, err, busy_in}. Writing
// STATUS with bit 1 set clears the sticky error flag.
//
// A write to CTRL (the last register) with merged bit 0 set raises a
// one-cycle doorbell that starts the pipeline. That happens only when the
// rasterizer is idle. If the rasterizer is busy, no doorbell is raised and
// err is flagged instead; CTRL is still loaded in both cases.
//
// Ports:
//   clk                - system clock, rising edge
//   reset              - synchronous, active-low reset
//   avs_address        - word address (ADDR_W bits)
//   avs_write          - write request
//   avs_writedata      - write data (32 bits)
//   avs_byteenable     - byte lanes for writes, bit i covers [8i+7:8i]
//   avs_read           - read request
//   avs_readdata       - read data, held between reads
//   avs_readdatavalid  - one-cycle read data qualifier
//   avs_waitrequest    - high while the bridge cannot accept a request
//   reg_q              - flattened Q outputs, register i at [WIDTH*i +: WIDTH]
//   reg_d              - merged data to every register's primary D input
//   reg_load_n         - active-low primary load strobes, at most one low
//   busy_in            - pipeline busy from the rasterizer
//   doorbell           - one-cycle pipeline start pulse
//   err                - sticky protocol error flag
//
// Parameter constraints: WIDTH must be 32 (4 byte lanes), and
// 2**ADDR_W must exceed NUM_REGS so that STATUS is addressable.
// ---------------------------------------------------------------------------
module gpu_reg_bridge #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         avs_address,
    input  logic                      avs_write,
    input  logic [WIDTH-1:0]          avs_writedata,
    input  logic [3:0]                avs_byteenable,
    input  logic                      avs_read,
    output logic [WIDTH-1:0]          avs_readdata,
    output logic                      avs_readdatavalid,
    output logic                      avs_waitrequest,
    input  logic [NUM_REGS*WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0]          reg_d,
    output logic [NUM_REGS-1:0]       reg_load_n,
    input  logic                      busy_in,
    output logic                      doorbell,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WMERGE  = 2'd1,
        WSTROBE = 2'd2,
        RDATA   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]   STATUS_ADDR = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0]   CTRL_ADDR   = ADDR_W'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0] ONE_HOT0    = NUM_REGS'(1);

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [3:0]         be_q;

    logic [WIDTH-1:0]   wr_q_sel;    // Q of the latched write target
    logic [WIDTH-1:0]   rd_q_sel;    // Q of the register being read
    logic [WIDTH-1:0]   merged;      // byte-merged write data
    logic [WIDTH-1:0]   read_value;  // value captured on read acceptance
    logic               err_set;
    logic               err_clr;

    // The bridge stalls the host whenever a transaction is in flight, and
    // also throughout reset.
    assign avs_waitrequest = (state != IDLE) || !reset;

    // Register selection by address compare. An out-of-range address
    // selects zero instead of indexing past the flattened bus.
    // NOTE: every always_comb output is given a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        wr_q_sel = '0;
        rd_q_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                wr_q_sel = reg_q[WIDTH*i +: WIDTH];
            end
            if (avs_address == ADDR_W'(i)) begin
                rd_q_sel = reg_q[WIDTH*i +: WIDTH];
            end
        end
    end

    // Each byte lane takes the host byte if it is enabled, and otherwise
    // keeps the register's current byte.
    always_comb begin
        merged = '0;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : wr_q_sel[8*b +: 8];
        end
    end

    // Read data is captured when the read is accepted, so it is valid
    // together with readdatavalid during the RDATA cycle.
    always_comb begin
        read_value = '0;
        if (avs_address < STATUS_ADDR) begin
            read_value = rd_q_sel;
        end else if (avs_address == STATUS_ADDR) begin
            read_value = {{(WIDTH-2){1'b0}}, err, busy_in};
        end
    end

    // Error sources and the W1C clear.
    always_comb begin
        err_set = 1'b0;
        err_clr = 1'b0;
        unique case (state)
            IDLE: begin
                // A simultaneous read and write is a protocol error; the
                // write wins and the read is dropped.
                if (avs_write && avs_read) begin
                    err_set = 1'b1;
                end else if (avs_read && (avs_address > STATUS_ADDR)) begin
                    err_set = 1'b1;
                end
            end
            WMERGE: begin
                if (addr_q > STATUS_ADDR) begin
                    err_set = 1'b1;
                end
                if ((addr_q == STATUS_ADDR) && wdata_q[1]) begin
                    err_clr = 1'b1;
                end
                // Kicking CTRL while the rasterizer is busy loses the
                // doorbell; flag it so software can detect the dropped start.
                if ((addr_q == CTRL_ADDR) && merged[0] && busy_in) begin
                    err_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Main control FSM with registered outputs. The strobe, reg_d and
    // doorbell are set on the WMERGE edge, so they are all valid together
    // during WSTROBE.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values no matter how the statements are
    // ordered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            be_q              <= '0;
            reg_d             <= '0;
            reg_load_n        <= '1;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            doorbell          <= 1'b0;
            err               <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    reg_load_n        <= '1;
                    doorbell          <= 1'b0;
                    avs_readdatavalid <= 1'b0;
                    if (avs_write || avs_read) begin
                        addr_q  <= avs_address;
                        wdata_q <= avs_writedata;
                        be_q    <= avs_byteenable;
                    end
                    if (avs_write) begin
                        state <= WMERGE;
                    end else if (avs_read) begin
                        avs_readdata      <= read_value;
                        avs_readdatavalid <= 1'b1;
                        state             <= RDATA;
                    end
                end

                WMERGE: begin
                    if (addr_q < STATUS_ADDR) begin
                        reg_d      <= merged;
                        reg_load_n <= ~(ONE_HOT0 << addr_q);
                        doorbell   <= (addr_q == CTRL_ADDR) && merged[0] && !busy_in;
                        state      <= WSTROBE;
                    end else begin
                        // STATUS write or out-of-range address: no strobe.
                        state <= IDLE;
                    end
                end

                WSTROBE: begin
                    // reg_d is left unchanged and stays stable after the load.
                    reg_load_n <= '1;
                    doorbell   <= 1'b0;
                    state      <= IDLE;
                end

                RDATA: begin
                    // avs_readdata keeps its value until the next read.
                    avs_readdatavalid <= 1'b0;
                    state             <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_gpu_reg_bridge
//
// Directed bench for gpu_reg_bridge. The register bank is modelled by an
// array that loads reg_d whenever the matching reg_load_n bit is low.
// Expected values are hand-computed constants.
//
// Timing convention: inputs are driven and outputs sampled 1 ns after a
// rising edge.
// ---------------------------------------------------------------------------
module tb_gpu_reg_bridge;

    localparam int WIDTH    = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [ADDR_W-1:0]         avs_address;
    logic                      avs_write;
    logic [WIDTH-1:0]          avs_writedata;
    logic [3:0]                avs_byteenable;
    logic                      avs_read;
    logic [WIDTH-1:0]          avs_readdata;
    logic                      avs_readdatavalid;
    logic                      avs_waitrequest;
    logic [NUM_REGS*WIDTH-1:0] reg_q;
    logic [WIDTH-1:0]          reg_d;
    logic [NUM_REGS-1:0]       reg_load_n;
    logic                      busy_in;
    logic                      doorbell;
    logic                      err;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] regs [NUM_REGS] = '{default: '0};

    always #5 clk = ~clk;

    // Register bank model: the primary load takes reg_d on a low strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!reg_load_n[i]) regs[i] <= reg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_q[WIDTH*i +: WIDTH] = regs[i];
    end

    gpu_reg_bridge #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .reg_q             (reg_q),
        .reg_d             (reg_d),
        .reg_load_n        (reg_load_n),
        .busy_in           (busy_in),
        .doorbell          (doorbell),
        .err               (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a write for exactly the accepting cycle. On return the DUT is
    // in WMERGE.
    task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick();
        avs_write      = 1'b0;
    endtask

    // On return the DUT is in RDATA, so readdatavalid should be visible.
    task automatic issue_read(input logic [ADDR_W-1:0] a);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
    endtask

    // Full write to an in-range register, returning once the DUT is idle.
    task automatic full_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        issue_write(a, d, be);
        tick();
        tick();
    endtask

    task automatic clear_err();
        issue_write(4'd8, 32'h2, 4'hF);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (reg_load_n !== 8'hFF) begin errors++; $display("FAIL reset_load_n: got %h want ff", reg_load_n); end
        checks++; if (reg_d !== 32'h0) begin errors++; $display("FAIL reset_reg_d: got %h want 0", reg_d); end
        checks++; if (avs_readdata !== 32'h0 || avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_read: got %h/%b want 0/0", avs_readdata, avs_readdatavalid); end
        checks++; if (doorbell !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got db=%b err=%b want 0/0", doorbell, err); end
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq: got %b want 1", avs_waitrequest); end
        reset = 1'b1;
        tick();
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL post_reset_waitreq: got %b want 0", avs_waitrequest); end
    endtask

    task automatic test_write_read();
        issue_write(4'd2, 32'hA5A5_1234, 4'hF);
        checks++; if (reg_load_n !== 8'hFF || avs_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_cycle1: got ln=%h wr=%b want ff/1", reg_load_n, avs_waitrequest); end
        tick();
        checks++; if (reg_load_n !== 8'hFB) begin errors++; $display("FAIL wr_strobe: got %h want fb", reg_load_n); end
        checks++; if (reg_d !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_data: got %h want a5a51234", reg_d); end
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_strobe_waitreq: got %b want 1", avs_waitrequest); end
        tick();
        checks++; if (reg_load_n !== 8'hFF || avs_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_done: got ln=%h wr=%b want ff/0", reg_load_n, avs_waitrequest); end
        checks++; if (reg_d !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_d_stable: got %h want a5a51234", reg_d); end
        issue_read(4'd2);
        checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hA5A5_1234) begin errors++; $display("FAIL rd_reg2: got %b/%h want 1/a5a51234", avs_readdatavalid, avs_readdata); end
        tick();
        checks++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'hA5A5_1234) begin errors++; $display("FAIL rd_hold: got %b/%h want 0/a5a51234", avs_readdatavalid, avs_readdata); end
    endtask

    task automatic test_byte_merge();
        full_write(4'd1, 32'h1122_3344, 4'hF);
        issue_write(4'd1, 32'hAABB_CCDD, 4'b0101);
        tick();
        checks++; if (reg_d !== 32'h11BB_33DD) begin errors++; $display("FAIL merge_data: got %h want 11bb33dd", reg_d); end
        checks++; if (reg_load_n !== 8'hFD) begin errors++; $display("FAIL merge_strobe: got %h want fd", reg_load_n); end
        tick();
        issue_read(4'd1);
        checks++; if (avs_readdata !== 32'h11BB_33DD) begin errors++; $display("FAIL merge_readback: got %h want 11bb33dd", avs_readdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Hold avs_read high; the second read is accepted two cycles after
        // the first.
        avs_address = 4'd2;
        avs_read    = 1'b1;
        tick();
        checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hA5A5_1234 || avs_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b/%h wr=%b want 1/a5a51234/1", avs_readdatavalid, avs_readdata, avs_waitrequest); end
        tick();
        checks++; if (avs_readdatavalid !== 1'b0 || avs_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_gap: got rdv=%b wr=%b want 0/0", avs_readdatavalid, avs_waitrequest); end
        avs_address = 4'd1;
        tick();
        avs_read = 1'b0;
        checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h11BB_33DD) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/11bb33dd", avs_readdatavalid, avs_readdata); end
        tick();
    endtask

    task automatic test_doorbell();
        busy_in = 1'b0;
        issue_write(4'd7, 32'h1, 4'hF);
        checks++; if (doorbell !== 1'b0) begin errors++; $display("FAIL db_early: got %b want 0", doorbell); end
        tick();
        checks++; if (doorbell !== 1'b1 || reg_load_n !== 8'h7F) begin errors++; $display("FAIL db_pulse: got db=%b ln=%h want 1/7f", doorbell, reg_load_n); end
        tick();
        checks++; if (doorbell !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL db_end: got db=%b err=%b want 0/0", doorbell, err); end
        busy_in = 1'b1;
        issue_write(4'd7, 32'h1, 4'hF);
        tick();
        checks++; if (doorbell !== 1'b0 || reg_load_n !== 8'h7F) begin errors++; $display("FAIL db_busy: got db=%b ln=%h want 0/7f", doorbell, reg_load_n); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL db_busy_err: got %b want 1", err); end
        issue_read(4'd8);
        checks++; if (avs_readdata !== 32'h3) begin errors++; $display("FAIL status_read: got %h want 3", avs_readdata); end
        tick();
        busy_in = 1'b0;
    endtask

    task automatic test_status_err();
        clear_err();
        checks++; if (err !== 1'b0 || avs_waitrequest !== 1'b0) begin errors++; $display("FAIL w1c_clear: got err=%b wr=%b want 0/0", err, avs_waitrequest); end
        issue_write(4'd12, 32'hFFFF_FFFF, 4'hF);
        checks++; if (reg_load_n !== 8'hFF) begin errors++; $display("FAIL oor_wr_c1: got %h want ff", reg_load_n); end
        tick();
        checks++; if (reg_load_n !== 8'hFF || err !== 1'b1) begin errors++; $display("FAIL oor_wr: got ln=%h err=%b want ff/1", reg_load_n, err); end
        clear_err();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL w1c_again: got %b want 0", err); end
        issue_read(4'd12);
        checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin errors++; $display("FAIL oor_rd: got %b/%h want 1/0", avs_readdatavalid, avs_readdata); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", err); end
    endtask

    task automatic test_collision();
        clear_err();
        avs_address    = 4'd5;
        avs_writedata  = 32'hDEAD_BEEF;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        checks++; if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL coll_wmerge: got wr=%b rdv=%b want 1/0", avs_waitrequest, avs_readdatavalid); end
        tick();
        checks++; if (avs_waitrequest !== 1'b1 || reg_load_n !== 8'hDF || avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL coll_wstrobe: got wr=%b ln=%h rdv=%b want 1/df/0", avs_waitrequest, reg_load_n, avs_readdatavalid); end
        tick();
        checks++; if (avs_readdatavalid !== 1'b0 || err !== 1'b1 || avs_waitrequest !== 1'b0) begin errors++; $display("FAIL coll_done: got rdv=%b err=%b wr=%b want 0/1/0", avs_readdatavalid, err, avs_waitrequest); end
        checks++; if (regs[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_loaded: got %h want deadbeef", regs[5]); end
    endtask

    task automatic test_reset_mid();
        clear_err();
        issue_write(4'd3, 32'h5555_AAAA, 4'hF);
        reset = 1'b0;
        tick();
        checks++; if (reg_load_n !== 8'hFF || avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_in: got ln=%h wr=%b want ff/1", reg_load_n, avs_waitrequest); end
        reset = 1'b1;
        tick();
        checks++; if (reg_load_n !== 8'hFF || avs_waitrequest !== 1'b0 || doorbell !== 1'b0) begin errors++; $display("FAIL rstmid_out: got ln=%h wr=%b db=%b want ff/0/0", reg_load_n, avs_waitrequest, doorbell); end
        tick();
        checks++; if (reg_load_n !== 8'hFF || avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got ln=%h rdv=%b want ff/0", reg_load_n, avs_readdatavalid); end
        issue_read(4'd3);
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rstmid_reg3: got %h want 0", avs_readdata); end
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        avs_address    = '0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        avs_read       = 1'b0;
        busy_in        = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_byte_merge();
        test_back_to_back();
        test_doorbell();
        test_status_err();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
